rggen_apb_register_initiator: RTL and testbench

Host-side initiator that converts APB4 slave transfers into single-cycle register access strobes for the bit fields of a register block, and returns their read data as the APB response. It sits between the system APB fabric and an array of `REGISTERS` word-aligned registers. It generates the write access, write data and write mask signals, and collects the read data that bit-field responders consume and produce.

---
 rtl/rggen_apb_register_initiator_if.sv | 26 ++
 rtl/rggen_apb_register_initiator.sv | 147 ++++++++++++++
 tb/tb_rggen_apb_register_initiator.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_apb_register_initiator_if.sv
// APB4 completer-side bundle for rggen_apb_register_initiator.
// Signal names keep the i_/o_ orientation as seen from the initiator block.
interface rggen_apb_register_initiator_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  logic                      i_psel;
  logic                      i_penable;
  logic [ADDRESS_WIDTH-1:0]  i_paddr;
  logic                      i_pwrite;
  logic [DATA_WIDTH-1:0]     i_pwdata;
  logic [DATA_WIDTH/8-1:0]   i_pstrb;
  logic                      o_pready;
  logic [DATA_WIDTH-1:0]     o_prdata;
  logic                      o_pslverr;

  modport master (
    output i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pstrb,
    input  o_pready, o_prdata, o_pslverr
  );

  modport slave (
    input  i_psel, i_penable, i_paddr, i_pwrite, i_pwdata, i_pstrb,
    output o_pready, o_prdata, o_pslverr
  );
endinterface

// File: rtl/rggen_apb_register_initiator.sv
// APB4 to register-strobe initiator: setup -> one-cycle access strobe -> pready.
// Optional macro RGGEN_APB_INITIATOR_SLVERR_EN: flag unmapped accesses with pslverr.
module rggen_apb_register_initiator #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int REGISTERS     = 4
)(
  input  logic                            clk,
  input  logic                            rst_n,
  rggen_apb_register_initiator_if.slave   apb,
  output logic [REGISTERS-1:0]            o_write_access,
  output logic [REGISTERS-1:0]            o_read_access,
  output logic [DATA_WIDTH-1:0]           o_write_data,
  output logic [DATA_WIDTH-1:0]           o_write_mask,
  input  logic [REGISTERS*DATA_WIDTH-1:0] i_read_data
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W = ADDRESS_WIDTH - LSB;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] RESPONSE = 2'd2;

  function automatic logic [DATA_WIDTH-1:0] expand_strobe(input logic [BYTES-1:0] strb);
    logic [DATA_WIDTH-1:0] mask;
    mask = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      mask[b] = strb[b/8];
    end
    return mask;
  endfunction

  function automatic logic [REGISTERS-1:0] decode_index(input logic [IDX_W-1:0] idx);
    logic [REGISTERS-1:0] dec;
    dec = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      dec[i] = (idx == IDX_W'(i));
    end
    return dec;
  endfunction

  logic [1:0]            state;
  logic [IDX_W-1:0]      idx_p0;
  logic                  mapped_p0;
  logic                  pready_p1;
  logic [DATA_WIDTH-1:0] prdata_p1;
  logic                  pslverr_p1;

  logic                  setup;
  logic [IDX_W-1:0]      setup_idx;
  logic                  setup_mapped;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  slverr_next;

  assign setup        = apb.i_psel && !apb.i_penable;
  assign setup_idx    = apb.i_paddr[ADDRESS_WIDTH-1:LSB];
  assign setup_mapped = ({1'b0, setup_idx} < (IDX_W+1)'(REGISTERS));

  generate
    if (LSB > 0) begin : g_byte_offset
      // Byte-offset bits inside a word never select a register.
      logic unused_offset;
      assign unused_offset = &{1'b0, apb.i_paddr[LSB-1:0]};
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (idx_p0 == IDX_W'(i)) begin
        sel_data = i_read_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef RGGEN_APB_INITIATOR_SLVERR_EN
  assign slverr_next = !mapped_p0;
`else
  assign slverr_next = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx_p0         <= '0;
      mapped_p0      <= 1'b0;
      o_write_access <= '0;
      o_read_access  <= '0;
      o_write_data   <= '0;
      o_write_mask   <= '0;
      pready_p1      <= 1'b0;
      prdata_p1      <= '0;
      pslverr_p1     <= 1'b0;
    end else begin
      case (state)
        // stage 0: setup phase latches the transfer and arms the strobe
        IDLE: begin
          if (setup) begin
            state     <= ACCESS;
            idx_p0    <= setup_idx;
            mapped_p0 <= setup_mapped;
            if (apb.i_pwrite) begin
              o_write_data <= apb.i_pwdata;
              o_write_mask <= expand_strobe(apb.i_pstrb);
            end
            o_write_access <= (apb.i_pwrite && (|apb.i_pstrb))
                              ? decode_index(setup_idx) : '0;
            o_read_access  <= (!apb.i_pwrite) ? decode_index(setup_idx) : '0;
          end
        end
        // stage 1: strobe cycle; capture read data and form the response
        ACCESS: begin
          o_write_access <= '0;
          o_read_access  <= '0;
          if (!apb.i_psel) begin
            state <= IDLE;
          end else begin
            state      <= RESPONSE;
            pready_p1  <= 1'b1;
            prdata_p1  <= mapped_p0 ? sel_data : '0;
            pslverr_p1 <= slverr_next;
          end
        end
        // stage 2: response presented for exactly one cycle
        RESPONSE: begin
          state      <= IDLE;
          pready_p1  <= 1'b0;
          prdata_p1  <= '0;
          pslverr_p1 <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          o_write_access <= '0;
          o_read_access  <= '0;
          pready_p1      <= 1'b0;
          prdata_p1      <= '0;
          pslverr_p1     <= 1'b0;
        end
      endcase
    end
  end

  assign apb.o_pready  = pready_p1;
  assign apb.o_prdata  = prdata_p1;
  assign apb.o_pslverr = pslverr_p1;
endmodule

// File: tb/tb_rggen_apb_register_initiator.sv
// Directed bench for rggen_apb_register_initiator with a small bit-field register model.
module tb_rggen_apb_register_initiator;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 4;
`ifdef RGGEN_APB_INITIATOR_SLVERR_EN
  localparam logic EXP_SLVERR = 1'b1;
`else
  localparam logic EXP_SLVERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rggen_apb_register_initiator_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) apb();

  logic [NR-1:0]    write_access;
  logic [NR-1:0]    read_access;
  logic [DW-1:0]    write_data;
  logic [DW-1:0]    write_mask;
  logic [NR*DW-1:0] read_data;
  logic [DW-1:0]    regs [NR] = '{default: '0};
  logic             ld_en = 1'b0;
  logic [1:0]       ld_idx = '0;
  logic [DW-1:0]    ld_val = '0;

  int total = 0;
  int bad = 0;

  rggen_apb_register_initiator #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .REGISTERS(NR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .apb            (apb.slave),
    .o_write_access (write_access),
    .o_read_access  (read_access),
    .o_write_data   (write_data),
    .o_write_mask   (write_mask),
    .i_read_data    (read_data)
  );

  // Bit fields: masked update on the write strobe, direct preload from the bench.
  always @(posedge clk) begin
    if (ld_en) regs[ld_idx] <= ld_val;
    for (int i = 0; i < NR; i++) begin
      if (write_access[i]) regs[i] <= (regs[i] & ~write_mask) | (write_data & write_mask);
    end
  end

  always_comb begin
    read_data = '0;
    for (int i = 0; i < NR; i++) read_data[i*DW +: DW] = regs[i];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input logic [3:0] s);
    apb.i_psel = 1'b1; apb.i_penable = 1'b0; apb.i_paddr = a;
    apb.i_pwrite = w; apb.i_pwdata = d; apb.i_pstrb = s;
  endtask

  task automatic idle_bus();
    apb.i_psel = 1'b0; apb.i_penable = 1'b0;
  endtask

  task automatic preload(input logic [1:0] idx, input logic [DW-1:0] val);
    ld_en = 1'b1; ld_idx = idx; ld_val = val;
    next_cycle();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({apb.o_pready, apb.o_pslverr, write_access, read_access} !== '0) begin
      bad++; $display("FAIL reset_ctrl: got %b required 0", {apb.o_pready, apb.o_pslverr, write_access, read_access});
    end
    total++;
    if ({apb.o_prdata, write_data, write_mask} !== '0) begin
      bad++; $display("FAIL reset_data: got %h required 0", {apb.o_prdata, write_data, write_mask});
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b0) begin
      bad++; $display("FAIL reset_idle_pready: got %b required 0", apb.o_pready);
    end
    next_cycle();
  endtask

  task automatic test_full_write();
    setup(8'h04, 1'b1, 32'hA5A5_1234, 4'hF);
    next_cycle(); apb.i_penable = 1'b1;
    @(negedge clk);
    total++;
    if (write_access !== 4'b0010 || read_access !== 4'b0000) begin
      bad++; $display("FAIL full_write_strobe: got wa=%b ra=%b required wa=0010 ra=0000", write_access, read_access);
    end
    total++;
    if (write_mask !== 32'hFFFF_FFFF || write_data !== 32'hA5A5_1234) begin
      bad++; $display("FAIL full_write_data: got mask=%h data=%h required mask=ffffffff data=a5a51234", write_mask, write_data);
    end
    total++;
    if (apb.o_pready !== 1'b0) begin
      bad++; $display("FAIL full_write_early_pready: got %b required 0", apb.o_pready);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b1 || apb.o_pslverr !== 1'b0 || write_access !== 4'b0000) begin
      bad++; $display("FAIL full_write_resp: got pready=%b pslverr=%b wa=%b required 1 0 0000", apb.o_pready, apb.o_pslverr, write_access);
    end
    next_cycle(); idle_bus();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b0) begin
      bad++; $display("FAIL full_write_pready_drop: got %b required 0", apb.o_pready);
    end
    next_cycle();
  endtask

  task automatic test_partial_write();
    preload(2'd2, 32'hFFFF_FFFF);
    setup(8'h08, 1'b1, 32'h1122_3344, 4'b0101);
    next_cycle(); apb.i_penable = 1'b1;
    @(negedge clk);
    total++;
    if (write_access !== 4'b0100 || write_mask !== 32'h00FF_00FF) begin
      bad++; $display("FAIL partial_write: got wa=%b mask=%h required wa=0100 mask=00ff00ff", write_access, write_mask);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b1) begin
      bad++; $display("FAIL partial_write_pready: got %b required 1", apb.o_pready);
    end
    next_cycle(); idle_bus();
  endtask

  task automatic test_back_to_back();
    setup(8'h08, 1'b0, 32'h0, 4'h0);
    next_cycle(); apb.i_penable = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b1 || apb.o_prdata !== 32'hFF22_FF44) begin
      bad++; $display("FAIL b2b_first: got pready=%b prdata=%h required 1 ff22ff44", apb.o_pready, apb.o_prdata);
    end
    next_cycle();
    setup(8'h04, 1'b0, 32'h0, 4'h0);
    next_cycle(); apb.i_penable = 1'b1;
    @(negedge clk);
    total++;
    if (read_access !== 4'b0010) begin
      bad++; $display("FAIL b2b_second_strobe: got %b required 0010", read_access);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b1 || apb.o_prdata !== 32'hA5A5_1234) begin
      bad++; $display("FAIL b2b_second: got pready=%b prdata=%h required 1 a5a51234", apb.o_pready, apb.o_prdata);
    end
    next_cycle(); idle_bus();
  endtask

  task automatic test_read();
    preload(2'd3, 32'hDEAD_BEEF);
    setup(8'h0C, 1'b0, 32'h0, 4'hF);
    next_cycle(); apb.i_penable = 1'b1;
    @(negedge clk);
    total++;
    if (read_access !== 4'b1000 || write_access !== 4'b0000) begin
      bad++; $display("FAIL read_strobe: got ra=%b wa=%b required ra=1000 wa=0000", read_access, write_access);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b1 || apb.o_prdata !== 32'hDEAD_BEEF || apb.o_pslverr !== 1'b0) begin
      bad++; $display("FAIL read_resp: got pready=%b prdata=%h pslverr=%b required 1 deadbeef 0", apb.o_pready, apb.o_prdata, apb.o_pslverr);
    end
    next_cycle(); idle_bus();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b0 || apb.o_prdata !== 32'h0) begin
      bad++; $display("FAIL read_after: got pready=%b prdata=%h required 0 0", apb.o_pready, apb.o_prdata);
    end
    next_cycle();
  endtask

  task automatic test_unmapped();
    setup(8'h10, 1'b0, 32'h0, 4'h0);
    next_cycle(); apb.i_penable = 1'b1;
    @(negedge clk);
    total++;
    if (read_access !== 4'b0000 || write_access !== 4'b0000) begin
      bad++; $display("FAIL unmapped_read_strobe: got ra=%b wa=%b required 0000 0000", read_access, write_access);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b1 || apb.o_prdata !== 32'h0 || apb.o_pslverr !== EXP_SLVERR) begin
      bad++; $display("FAIL unmapped_read_resp: got pready=%b prdata=%h pslverr=%b required 1 0 %b", apb.o_pready, apb.o_prdata, apb.o_pslverr, EXP_SLVERR);
    end
    next_cycle();
    setup(8'h14, 1'b1, 32'hFFFF_FFFF, 4'hF);
    next_cycle(); apb.i_penable = 1'b1;
    @(negedge clk);
    total++;
    if (write_access !== 4'b0000) begin
      bad++; $display("FAIL unmapped_write_strobe: got %b required 0000", write_access);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b1 || apb.o_pslverr !== EXP_SLVERR) begin
      bad++; $display("FAIL unmapped_write_resp: got pready=%b pslverr=%b required 1 %b", apb.o_pready, apb.o_pslverr, EXP_SLVERR);
    end
    next_cycle(); idle_bus();
  endtask

  task automatic test_zero_strobe();
    setup(8'h00, 1'b1, 32'h5555_5555, 4'h0);
    next_cycle(); apb.i_penable = 1'b1;
    @(negedge clk);
    total++;
    if (write_access !== 4'b0000) begin
      bad++; $display("FAIL zero_strobe_access: got %b required 0000", write_access);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b1 || apb.o_pslverr !== 1'b0) begin
      bad++; $display("FAIL zero_strobe_resp: got pready=%b pslverr=%b required 1 0", apb.o_pready, apb.o_pslverr);
    end
    next_cycle(); idle_bus();
  endtask

  task automatic test_abort();
    setup(8'h00, 1'b1, 32'h0000_00AA, 4'hF);
    next_cycle(); idle_bus();
    @(negedge clk);
    total++;
    if (write_access !== 4'b0001) begin
      bad++; $display("FAIL abort_strobe: got %b required 0001", write_access);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b0) begin
      bad++; $display("FAIL abort_no_pready: got %b required 0", apb.o_pready);
    end
    next_cycle();
    setup(8'h00, 1'b0, 32'h0, 4'h0);
    next_cycle(); apb.i_penable = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b1 || apb.o_prdata !== 32'h0000_00AA) begin
      bad++; $display("FAIL abort_readback: got pready=%b prdata=%h required 1 000000aa", apb.o_pready, apb.o_prdata);
    end
    next_cycle(); idle_bus();
  endtask

  task automatic test_reset_mid();
    setup(8'h00, 1'b1, 32'h1234_5678, 4'hF);
    next_cycle(); apb.i_penable = 1'b1;
    @(negedge clk);
    total++;
    if (write_access !== 4'b0001) begin
      bad++; $display("FAIL reset_mid_strobe: got %b required 0001", write_access);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({write_access, read_access, apb.o_pready, apb.o_pslverr} !== '0 ||
        {apb.o_prdata, write_data, write_mask} !== '0) begin
      bad++; $display("FAIL reset_mid_clear: got wa=%b data=%h mask=%h required all 0", write_access, write_data, write_mask);
    end
    next_cycle(); idle_bus();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b0) begin
      bad++; $display("FAIL reset_mid_no_resp: got %b required 0", apb.o_pready);
    end
    next_cycle();
    setup(8'h00, 1'b0, 32'h0, 4'h0);
    next_cycle(); apb.i_penable = 1'b1;
    @(negedge clk);
    total++;
    if (read_access !== 4'b0001) begin
      bad++; $display("FAIL reset_mid_next_strobe: got %b required 0001", read_access);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (apb.o_pready !== 1'b1 || apb.o_prdata !== 32'h0000_00AA) begin
      bad++; $display("FAIL reset_mid_next_resp: got pready=%b prdata=%h required 1 000000aa", apb.o_pready, apb.o_prdata);
    end
    next_cycle(); idle_bus();
    next_cycle();
  endtask

  initial begin
    idle_bus();
    apb.i_paddr = '0; apb.i_pwrite = 1'b0; apb.i_pwdata = '0; apb.i_pstrb = '0;
    test_reset();
    test_full_write();
    test_partial_write();
    test_back_to_back();
    test_read();
    test_unmapped();
    test_zero_strobe();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
